// File: rtl/bus_ctrl.sv
// Bus transaction controller: latches a decoded CPU request, strobes one device, returns ack/err.
// Optional ack watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_ctrl #(
    parameter int unsigned     NDEV        = 9,
    parameter logic [NDEV-1:0] WAIT_MASK   = 9'h040,
    parameter int unsigned     WAIT_CYCLES = 6,
    parameter int unsigned     TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_cyc,
    input  logic                 cpu_we,
    input  logic [3:0]           cpu_be,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    input  logic [NDEV-1:0]      sel,
    input  logic                 sel_invalid,
    output logic [NDEV-1:0]      dev_cyc,
    output logic                 dev_we,
    output logic [3:0]           dev_be,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    input  logic [NDEV-1:0]      dev_ack,
    input  logic [32*NDEV-1:0]   dev_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    // Counter only needs to reach the larger of the two limits; it saturates there.
    localparam int unsigned CNT_MAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
    localparam logic [NDEV-1:0] ONE = {{(NDEV-1){1'b0}}, 1'b1};

    state_t          state;
    logic [NDEV-1:0] sel_q;
    logic [15:0]     cnt;
    logic            aborted;

    logic            one_hot;
    logic            ack_hit;
    logic            fixed_wait;
    logic            done_now;
    logic            timeout_now;
    logic [31:0]     rdata_mux;

    always_comb begin
        one_hot    = (sel != '0) && ((sel & (sel - ONE)) == '0);
        ack_hit    = |(dev_ack & sel_q);
        fixed_wait = |(sel_q & WAIT_MASK);
        done_now   = fixed_wait ? (cnt == 16'(WAIT_CYCLES)) : ack_hit;
`ifdef BUS_TIMEOUT_EN
        timeout_now = !fixed_wait && !ack_hit && (cnt == 16'(TIMEOUT));
`else
        timeout_now = 1'b0;
`endif
    end

    always_comb begin
        rdata_mux = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            if (sel_q[i]) rdata_mux = rdata_mux | dev_rdata[32*i +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= '0;
            cnt       <= '0;
            aborted   <= 1'b0;
            dev_cyc   <= '0;
            dev_we    <= 1'b0;
            dev_be    <= '0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_cyc) begin
                        dev_we    <= cpu_we;
                        dev_be    <= cpu_be;
                        dev_addr  <= cpu_addr;
                        dev_wdata <= cpu_wdata;
                        sel_q     <= sel;
                        aborted   <= 1'b0;
                        cnt       <= 16'd1;
                        if (sel_invalid || !one_hot) begin
                            state   <= ERR;
                            cpu_err <= 1'b1;
                        end else begin
                            state   <= ACCESS;
                            dev_cyc <= sel;
                        end
                    end
                end
                ACCESS: begin
                    if (!cpu_cyc) aborted <= 1'b1;
                    // An abandoned request still finishes its device cycle, silently.
                    if (done_now) begin
                        cpu_rdata <= rdata_mux;
                        dev_cyc   <= '0;
                        if (aborted || !cpu_cyc) begin
                            state <= IDLE;
                        end else begin
                            state   <= DONE;
                            cpu_ack <= 1'b1;
                        end
                    end else if (timeout_now) begin
                        dev_cyc <= '0;
                        if (aborted || !cpu_cyc) begin
                            state <= IDLE;
                        end else begin
                            state   <= ERR;
                            cpu_err <= 1'b1;
                        end
                    end else if (cnt != 16'(CNT_MAX)) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed table-driven bench for bus_ctrl, plus hand sequences for abort, reset and timeout.
module tb_bus_ctrl;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_cyc;
    logic              cpu_we;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic [8:0]        sel;
    logic              sel_invalid;
    logic [8:0]        dev_cyc;
    logic              dev_we;
    logic [3:0]        dev_be;
    logic [31:0]       dev_addr;
    logic [31:0]       dev_wdata;
    logic [8:0]        dev_ack;
    logic [32*9-1:0]   dev_rdata;

    int checks = 0;
    int errors = 0;

    bus_ctrl #(
        .NDEV(9),
        .WAIT_MASK(9'h040),
        .WAIT_CYCLES(6),
        .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_cyc(cpu_cyc), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .sel(sel), .sel_invalid(sel_invalid),
        .dev_cyc(dev_cyc), .dev_we(dev_we), .dev_be(dev_be), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [8:0]  sel;
        logic        inv;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [8:0]  stray;
        int          ack_after;  // dev_cyc-high cycles seen before the device acks; -1 = never
        bit          exp_err;
        int          exp_n;      // edge index (0 = request accepted) at which ack/err appears
        int          exp_hc;     // cycles dev_cyc is observed high
    } vec_t;

    vec_t vecs[10];
    logic [31:0] last_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  n;
        int  hc;
        bit  done;
        for (int i = 0; i < 9; i++) begin
            dev_rdata[32*i +: 32] = 32'(32'h11111111 * (i + 1));
            if (v.sel[i]) dev_rdata[32*i +: 32] = v.rdata;
        end
        dev_ack     = v.stray;
        cpu_we      = v.we;
        cpu_be      = v.be;
        cpu_addr    = v.addr;
        cpu_wdata   = v.wdata;
        sel         = v.sel;
        sel_invalid = v.inv;
        cpu_cyc     = 1'b1;
        n = 0; hc = 0; done = 0;
        while (!done && n < 50) begin
            step();
            if (cpu_ack || cpu_err) begin
                done = 1;
                check({v.name, " kind"}, {63'd0, cpu_err}, {63'd0, v.exp_err});
                check({v.name, " latency"}, 64'(n), 64'(v.exp_n));
                check({v.name, " dev_cyc_cycles"}, 64'(hc), 64'(v.exp_hc));
                check({v.name, " dev_cyc_off"}, 64'(dev_cyc), 64'd0);
                if (!v.exp_err && !v.we)
                    check({v.name, " rdata"}, 64'(cpu_rdata), 64'(v.rdata));
                else if (v.exp_err)
                    check({v.name, " rdata_held"}, 64'(cpu_rdata), 64'(last_rdata));
            end else begin
                if (dev_cyc != '0) begin
                    hc++;
                    if (hc == 1) begin
                        check({v.name, " dev_cyc"}, 64'(dev_cyc), 64'(v.sel));
                        check({v.name, " dev_fields"}, {dev_we, dev_be, dev_addr, dev_wdata},
                              {v.we, v.be, v.addr, v.wdata});
                    end
                    if (v.ack_after >= 0 && hc >= v.ack_after) dev_ack = v.stray | v.sel;
                end
                n++;
            end
        end
        if (!done) check({v.name, " completion_timeout"}, 64'd0, 64'd1);
        cpu_cyc = 1'b0;
        dev_ack = '0;
        step();
        check({v.name, " one_cycle_pulse"}, {62'd0, cpu_ack, cpu_err}, 64'd0);
        if (!v.exp_err && !v.we) begin
            check({v.name, " rdata_hold"}, 64'(cpu_rdata), 64'(v.rdata));
            last_rdata = v.rdata;
        end else if (!v.exp_err) begin
            last_rdata = cpu_rdata;  // write data returned is don't-care; track what is held
        end
    endtask

    initial begin
        //         name               sel     inv we  be      addr           wdata          rdata          stray   ack err n  hc
        vecs[0] = '{"sram_rd",        9'h001, 0, 0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 9'h000,  2, 0, 2, 2};
        vecs[1] = '{"flash_rd",       9'h040, 0, 0, 4'hF, 32'h0100_0000, 32'h0,         32'hCAFEF00D, 9'h000, -1, 0, 6, 6};
        vecs[2] = '{"invalid",        9'h000, 1, 0, 4'hF, 32'h0010_0000, 32'h0,         32'h0,        9'h000, -1, 1, 0, 0};
        vecs[3] = '{"ambiguous",      9'h081, 0, 0, 4'hF, 32'h0000_2000, 32'h0,         32'h0,        9'h000, -1, 1, 0, 0};
        vecs[4] = '{"no_sel",         9'h000, 0, 0, 4'hF, 32'h0000_3000, 32'h0,         32'h0,        9'h000, -1, 1, 0, 0};
        vecs[5] = '{"min_latency",    9'h100, 0, 0, 4'hF, 32'h8000_0000, 32'h0,         32'h13572468, 9'h000,  1, 0, 1, 1};
        vecs[6] = '{"write",          9'h002, 0, 1, 4'h3, 32'h2000_0004, 32'hA5A55A5A, 32'h0,        9'h000,  3, 0, 3, 3};
        vecs[7] = '{"flash_early_ack",9'h040, 0, 0, 4'hF, 32'h0100_0040, 32'h0,         32'h0BADC0DE, 9'h000,  1, 0, 6, 6};
        vecs[8] = '{"stray_ack",      9'h004, 0, 0, 4'hC, 32'h3000_0008, 32'h0,         32'h600DF00D, 9'h008,  3, 0, 3, 3};
        vecs[9] = '{"inv_with_sel",   9'h002, 1, 1, 4'hF, 32'h0000_4000, 32'h12345678, 32'h0,        9'h000, -1, 1, 0, 0};

        rst_n = 1'b0; cpu_cyc = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
        sel = '0; sel_invalid = 1'b0; dev_ack = '0; dev_rdata = '0;
        step();
        step();
        check("reset_outputs", {dev_cyc, cpu_ack, cpu_err, cpu_rdata, dev_we, dev_be} , 64'd0);
        check("reset_fields", {dev_addr, dev_wdata}, 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Abort: drop cpu_cyc mid-ACCESS, device still completes, no ack, FSM back in IDLE.
        sel = 9'h001; sel_invalid = 1'b0; cpu_we = 1'b0; dev_rdata[31:0] = 32'h55AA55AA;
        cpu_cyc = 1'b1;
        step();
        check("abort dev_cyc_start", 64'(dev_cyc), 64'h001);
        cpu_cyc = 1'b0;
        step();
        check("abort dev_cyc_runs", 64'(dev_cyc), 64'h001);
        dev_ack = 9'h001;
        step();
        check("abort no_ack", {55'd0, dev_cyc, cpu_ack, cpu_err} , 64'd0);
        dev_ack = '0;
        sel = 9'h002; cpu_cyc = 1'b1;
        step();
        check("abort idle_next", {53'd0, dev_cyc, cpu_ack, cpu_err}, {53'd0, 9'h002, 2'b00});
        dev_ack = 9'h002; dev_rdata[63:32] = 32'h0F0F0F0F;
        step();
        check("abort next_ack", {31'd0, cpu_ack, cpu_rdata}, {31'd0, 1'b1, 32'h0F0F0F0F});
        cpu_cyc = 1'b0; dev_ack = '0;
        step();

        // Asynchronous reset in the middle of an access.
        sel = 9'h080; cpu_cyc = 1'b1;
        step();
        step();
        check("rst_mid dev_cyc_before", 64'(dev_cyc), 64'h080);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid outputs", {dev_cyc, cpu_ack, cpu_err, cpu_rdata, dev_we, dev_be}, 64'd0);
        check("rst_mid fields", {dev_addr, dev_wdata}, 64'd0);
        cpu_cyc = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Ack device that never answers.
        begin
            int hc;
            int err_n;
            bit bad;
            hc = 0; err_n = -1; bad = 0;
            sel = 9'h080; cpu_cyc = 1'b1;
`ifdef BUS_TIMEOUT_EN
            for (int n = 0; n < 20 && err_n < 0; n++) begin
                step();
                if (cpu_err) err_n = n;
                else if (dev_cyc == 9'h080) hc++;
            end
            check("timeout dev_cyc_cycles", 64'(hc), 64'd4);
            check("timeout err_edge", 64'(err_n), 64'd4);
            check("timeout rdata_held", 64'(cpu_rdata), 64'(32'h0));
            cpu_cyc = 1'b0;
            step();
            check("timeout pulse", {62'd0, cpu_ack, cpu_err}, 64'd0);
`else
            for (int n = 0; n < 1000; n++) begin
                step();
                if (dev_cyc == 9'h080) hc++;
                if (cpu_err || cpu_ack) bad = 1;
            end
            check("no_timeout dev_cyc_cycles", 64'(hc), 64'd1000);
            check("no_timeout no_err", {63'd0, bad}, 64'd0);
            cpu_cyc = 1'b0;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
